// File: rtl/gen1_pkg.sv
// Shared encodings for the gen1 core: opcode/funct/cp0-rs fields, ALU op codes
// and the bundle of decoded control strobes.
package gen1_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_CP0   = 6'h10;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL     = 6'h00;
   localparam logic [5:0] FN_SRL     = 6'h02;
   localparam logic [5:0] FN_SRA     = 6'h03;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;
   localparam logic [5:0] FN_SYSRET  = 6'h18;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_SUB     = 6'h22;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_XOR     = 6'h26;
   localparam logic [5:0] FN_NOR     = 6'h27;
   localparam logic [5:0] FN_SLT     = 6'h2A;

   localparam logic [4:0] RS_MFC0   = 5'h00;
   localparam logic [4:0] RS_MTC0   = 5'h04;
   localparam logic [4:0] RS_SYSRET = 5'h10;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_XOR = 4'b0011,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_SLL = 4'b1000,
      ALU_SRL = 4'b1001,
      ALU_SRA = 4'b1010,
      ALU_LUI = 4'b1011,
      ALU_NOR = 4'b1100
   } alu_op_t;

   typedef struct packed {
      logic regdst;
      logic jump;
      logic branch;
      logic memread;
      logic memtoreg;
      logic memwrite;
      logic alusrc;
      logic regwrite;
      logic linkpc;
      logic jumpreg;
      logic swapflags;
      logic readsys;
      logic writesys;
      logic sysret;
      logic badinstr;
   } ctrl_t;

endpackage

// File: rtl/gen1_alu_core.sv
// gen1 ALU: operation select on a 4-bit code plus zero flag.
module gen1_alu_core
   import gen1_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [3:0]      alucntrl,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam int unsigned SHW = $clog2(XLEN);

   logic [SHW-1:0] shamt;

   assign shamt = b[SHW-1:0];

   always_comb begin
      result = '0;
      case (alu_op_t'(alucntrl))
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_XOR: result = a ^ b;
         ALU_SUB: result = a - b;
         ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_NOR: result = ~(a | b);
         ALU_SLL: result = a << shamt;
         ALU_SRL: result = a >> shamt;
         ALU_SRA: result = $signed(a) >>> shamt;
         ALU_LUI: result = b << 16;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/gen1_decode_exec.sv
// Decode/execute slice of the gen1 single-cycle core: control decode, ALU B
// operand select, ALU and a registered copy of the ALU result.
module gen1_decode_exec
   import gen1_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     instr,
   input  logic            sysmode,
   input  logic [XLEN-1:0] rd1,
   input  logic [XLEN-1:0] rd2,
   input  logic [XLEN-1:0] imm_ext,
   output logic            regdst,
   output logic            jump,
   output logic            branch,
   output logic            memread,
   output logic            memtoreg,
   output logic            memwrite,
   output logic            alusrc,
   output logic            regwrite,
   output logic            linkpc,
   output logic            jumpreg,
   output logic            swapflags,
   output logic            readsys,
   output logic            writesys,
   output logic            sysret,
   output logic            badinstr,
   output logic [3:0]      alucntrl,
   output logic [XLEN-1:0] alu_b,
   output logic [XLEN-1:0] alu_result,
   output logic            zero,
   output logic [XLEN-1:0] alu_result_q
);

   logic [5:0] opcode;
   logic [4:0] rs;
   logic [5:0] funct;
   logic       unused_instr;
   ctrl_t      dec;
   alu_op_t    dec_op;
   ctrl_t      ctrl;
   alu_op_t    alu_op;

   assign opcode       = instr[31:26];
   assign rs           = instr[25:21];
   assign funct        = instr[5:0];
   assign unused_instr = ^instr[20:6];

   always_comb begin
      dec    = '0;
      dec_op = ALU_AND;
      case (opcode)
         OP_RTYPE: begin
            dec.regdst   = 1'b1;
            dec.regwrite = 1'b1;
            case (funct)
               FN_ADD: dec_op = ALU_ADD;
               FN_SUB: dec_op = ALU_SUB;
               FN_AND: dec_op = ALU_AND;
               FN_OR:  dec_op = ALU_OR;
               FN_XOR: dec_op = ALU_XOR;
               FN_NOR: dec_op = ALU_NOR;
               FN_SLT: dec_op = ALU_SLT;
               FN_SLL: dec_op = ALU_SLL;
               FN_SRL: dec_op = ALU_SRL;
               FN_SRA: dec_op = ALU_SRA;
               FN_JR, FN_JALR: begin
                  dec.regwrite = 1'b0;
                  dec.jumpreg  = 1'b1;
                  dec.linkpc   = (funct == FN_JALR);
                  dec_op       = ALU_ADD;
               end
               FN_SYSCALL: begin
                  dec.regwrite  = 1'b0;
                  dec.swapflags = 1'b1;
               end
               default: dec.badinstr = 1'b1;
            endcase
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: begin
            dec.alusrc   = 1'b1;
            dec.regwrite = (opcode != OP_SW);
            dec.memread  = (opcode == OP_LW);
            dec.memtoreg = (opcode == OP_LW);
            dec.memwrite = (opcode == OP_SW);
            case (opcode)
               OP_SLTI: dec_op = ALU_SLT;
               OP_ANDI: dec_op = ALU_AND;
               OP_ORI:  dec_op = ALU_OR;
               OP_XORI: dec_op = ALU_XOR;
               OP_LUI:  dec_op = ALU_LUI;
               default: dec_op = ALU_ADD;
            endcase
         end
         OP_BEQ: begin
            dec.branch = 1'b1;
            dec_op     = ALU_SUB;
         end
         OP_J, OP_JAL: begin
            dec.jump   = 1'b1;
            dec.linkpc = (opcode == OP_JAL);
         end
         OP_CP0: begin
            if (!sysmode) begin
               dec.badinstr = 1'b1;
            end else if (rs == RS_MFC0) begin
               dec.readsys = 1'b1;
            end else if (rs == RS_MTC0) begin
               dec.writesys = 1'b1;
            end else if (rs == RS_SYSRET && funct == FN_SYSRET) begin
               dec.sysret = 1'b1;
            end else begin
               dec.badinstr = 1'b1;
            end
         end
         default: dec.badinstr = 1'b1;
      endcase
   end

   // A faulting instruction keeps only badinstr; reset silences everything.
   always_comb begin
      ctrl   = dec;
      alu_op = dec_op;
      if (reset) begin
         ctrl   = '0;
         alu_op = ALU_AND;
      end else if (dec.badinstr) begin
         ctrl          = '0;
         ctrl.badinstr = 1'b1;
         alu_op        = ALU_AND;
      end
   end

   assign regdst    = ctrl.regdst;
   assign jump      = ctrl.jump;
   assign branch    = ctrl.branch;
   assign memread   = ctrl.memread;
   assign memtoreg  = ctrl.memtoreg;
   assign memwrite  = ctrl.memwrite;
   assign alusrc    = ctrl.alusrc;
   assign regwrite  = ctrl.regwrite;
   assign linkpc    = ctrl.linkpc;
   assign jumpreg   = ctrl.jumpreg;
   assign swapflags = ctrl.swapflags;
   assign readsys   = ctrl.readsys;
   assign writesys  = ctrl.writesys;
   assign sysret    = ctrl.sysret;
   assign badinstr  = ctrl.badinstr;
   assign alucntrl  = alu_op;

   assign alu_b = alusrc ? imm_ext : rd2;

   gen1_alu_core #(.XLEN(XLEN)) u_alu (
      .alucntrl (alucntrl),
      .a        (rd1),
      .b        (alu_b),
      .result   (alu_result),
      .zero     (zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_result_q <= '0;
      end else begin
         alu_result_q <= alu_result;
      end
   end

endmodule

// File: tb/tb_gen1_decode_exec.sv
// Bench for gen1_decode_exec: directed cases plus random instructions checked
// against a mnemonic-level reference model.
module tb_gen1_decode_exec;

   localparam int unsigned XLEN = 32;

   typedef struct packed {
      logic regdst, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite;
      logic linkpc, jumpreg, swapflags, readsys, writesys, sysret, badinstr;
   } strb_t;

   logic            clk;
   logic            reset;
   logic [31:0]     instr;
   logic            sysmode;
   logic [XLEN-1:0] rd1, rd2, imm_ext;
   logic regdst, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite;
   logic linkpc, jumpreg, swapflags, readsys, writesys, sysret, badinstr;
   logic [3:0]      alucntrl;
   logic [XLEN-1:0] alu_b, alu_result, alu_result_q;
   logic            zero;

   int n_cmp = 0;
   int n_bad = 0;

   logic [5:0] op_tab [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0A, 6'h0C,
                               6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h23, 6'h2B};
   logic [5:0] fn_tab [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                               6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h0C, 6'h18};
   logic [4:0] rs_tab [3]  = '{5'h00, 5'h04, 5'h10};

   gen1_decode_exec #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .instr(instr), .sysmode(sysmode),
      .rd1(rd1), .rd2(rd2), .imm_ext(imm_ext),
      .regdst(regdst), .jump(jump), .branch(branch), .memread(memread),
      .memtoreg(memtoreg), .memwrite(memwrite), .alusrc(alusrc), .regwrite(regwrite),
      .linkpc(linkpc), .jumpreg(jumpreg), .swapflags(swapflags), .readsys(readsys),
      .writesys(writesys), .sysret(sysret), .badinstr(badinstr), .alucntrl(alucntrl),
      .alu_b(alu_b), .alu_result(alu_result), .zero(zero), .alu_result_q(alu_result_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] r_ins(input logic [5:0] fn);
      return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op);
      return {op, 5'd1, 5'd2, 16'h0008};
   endfunction

   function automatic logic [31:0] c_ins(input logic [4:0] rs, input logic [5:0] fn);
      return {6'h10, rs, 15'h0, fn};
   endfunction

   // Reference model: classify instruction into a mnemonic.
   function automatic string mnem(input logic [31:0] i, input logic sm);
      logic [5:0] op = i[31:26];
      logic [4:0] rs = i[25:21];
      logic [5:0] fn = i[5:0];
      case (op)
         6'h00: case (fn)
            6'h20: return "ADD";  6'h22: return "SUB";  6'h24: return "AND";
            6'h25: return "OR";   6'h26: return "XOR";  6'h27: return "NOR";
            6'h2A: return "SLT";  6'h00: return "SLL";  6'h02: return "SRL";
            6'h03: return "SRA";  6'h08: return "JR";   6'h09: return "JALR";
            6'h0C: return "SYSCALL";
            default: return "BAD";
         endcase
         6'h08: return "ADDI"; 6'h0A: return "SLTI"; 6'h0C: return "ANDI";
         6'h0D: return "ORI";  6'h0E: return "XORI"; 6'h0F: return "LUI";
         6'h23: return "LW";   6'h2B: return "SW";   6'h04: return "BEQ";
         6'h02: return "J";    6'h03: return "JAL";
         6'h10: begin
            if (!sm) return "BAD";
            if (rs == 5'h00) return "MFC0";
            if (rs == 5'h04) return "MTC0";
            if (rs == 5'h10 && fn == 6'h18) return "SYSRET";
            return "BAD";
         end
         default: return "BAD";
      endcase
   endfunction

   function automatic strb_t exp_strb(input string nm);
      strb_t s = '0;
      case (nm)
         "ADD", "SUB", "AND", "OR", "XOR", "NOR", "SLT", "SLL", "SRL", "SRA":
            begin s.regdst = 1; s.regwrite = 1; end
         "JR":      begin s.regdst = 1; s.jumpreg = 1; end
         "JALR":    begin s.regdst = 1; s.jumpreg = 1; s.linkpc = 1; end
         "SYSCALL": begin s.regdst = 1; s.swapflags = 1; end
         "ADDI", "SLTI", "ANDI", "ORI", "XORI", "LUI":
            begin s.alusrc = 1; s.regwrite = 1; end
         "LW": begin s.alusrc = 1; s.regwrite = 1; s.memread = 1; s.memtoreg = 1; end
         "SW":     begin s.alusrc = 1; s.memwrite = 1; end
         "BEQ":    s.branch = 1;
         "J":      s.jump = 1;
         "JAL":    begin s.jump = 1; s.linkpc = 1; end
         "MFC0":   s.readsys = 1;
         "MTC0":   s.writesys = 1;
         "SYSRET": s.sysret = 1;
         "BAD":    s.badinstr = 1;
         default:  s = '0;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] exp_code(input string nm);
      case (nm)
         "ADD", "ADDI", "LW", "SW", "JR", "JALR": return 4'b0010;
         "SUB", "BEQ":   return 4'b0110;
         "OR", "ORI":    return 4'b0001;
         "XOR", "XORI":  return 4'b0011;
         "NOR":          return 4'b1100;
         "SLT", "SLTI":  return 4'b0111;
         "SLL":          return 4'b1000;
         "SRL":          return 4'b1001;
         "SRA":          return 4'b1010;
         "LUI":          return 4'b1011;
         default:        return 4'b0000;
      endcase
   endfunction

   // Non-ALU forms, faults and reset leave the code at 0, i.e. A AND B.
   function automatic logic [31:0] exp_alu(input string nm, input logic [31:0] a, input logic [31:0] b);
      int sh = int'(b[4:0]);
      case (nm)
         "ADD", "ADDI", "LW", "SW", "JR", "JALR": return a + b;
         "SUB", "BEQ":  return a - b;
         "OR", "ORI":   return a | b;
         "XOR", "XORI": return a ^ b;
         "NOR":         return ~(a | b);
         "SLT", "SLTI": return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         "SLL":         return a << sh;
         "SRL":         return a >> sh;
         "SRA":         return 32'($signed(a) >>> sh);
         "LUI":         return {b[15:0], 16'h0000};
         default:       return a & b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [31:0] i, input logic sm, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic rst);
      string       nm;
      strb_t       es, os;
      logic [31:0] eb, er;
      @(negedge clk);
      instr = i; sysmode = sm; rd1 = a; rd2 = b; imm_ext = im; reset = rst;
      #1;
      nm = rst ? "RESET" : mnem(i, sm);
      es = exp_strb(nm);
      eb = es.alusrc ? im : b;
      er = exp_alu(nm, a, eb);
      os = {regdst, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite,
            linkpc, jumpreg, swapflags, readsys, writesys, sysret, badinstr};
      chk({nm, "_strobes"}, 64'(os), 64'(es));
      chk({nm, "_alucntrl"}, 64'(alucntrl), 64'(exp_code(nm)));
      chk({nm, "_alu_b"}, 64'(alu_b), 64'(eb));
      chk({nm, "_alu_result"}, 64'(alu_result), 64'(er));
      chk({nm, "_zero"}, 64'(zero), 64'(er == 32'd0));
      @(posedge clk);
      #1;
      chk({nm, "_alu_result_q"}, 64'(alu_result_q), rst ? 64'd0 : 64'(er));
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] i = $urandom;
      if ($urandom_range(0, 9) != 0) i[31:26] = op_tab[$urandom_range(0, 12)];
      if ((i[31:26] == 6'h00 || i[31:26] == 6'h10) && $urandom_range(0, 3) != 0)
         i[5:0] = fn_tab[$urandom_range(0, 13)];
      if (i[31:26] == 6'h10 && $urandom_range(0, 3) != 0) begin
         i[25:21] = rs_tab[$urandom_range(0, 2)];
         if (i[25:21] == 5'h10 && $urandom_range(0, 1) == 0) i[5:0] = 6'h18;
      end
      return i;
   endfunction

   initial begin
      logic [31:0] a, b;
      reset = 1'b1; instr = '0; sysmode = 1'b0; rd1 = '0; rd2 = '0; imm_ext = '0;
      repeat (2) @(posedge clk);

      step(r_ins(6'h20), 1'b0, 32'd5, 32'd7, 32'd0, 1'b1);
      chk("reset_regdst", 64'(regdst), 64'd0);

      step(r_ins(6'h20), 1'b0, 32'd5, 32'd7, 32'd0, 1'b0);
      chk("add_result", 64'(alu_result), 64'd12);
      step(i_ins(6'h04), 1'b0, 32'h1234, 32'h1234, 32'd0, 1'b0);
      chk("beq_zero", 64'(zero), 64'd1);
      step(r_ins(6'h2A), 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      chk("slt_result", 64'(alu_result), 64'd1);
      step(i_ins(6'h23), 1'b0, 32'h100, 32'd3, 32'd8, 1'b0);
      chk("lw_result", 64'(alu_result), 64'h108);
      step(i_ins(6'h2B), 1'b0, 32'h100, 32'd3, 32'd8, 1'b0);
      chk("sw_memwrite", 64'(memwrite), 64'd1);
      step(c_ins(5'h04, 6'h00), 1'b1, 32'd1, 32'd2, 32'd0, 1'b0);
      chk("mtc0_sys_writesys", 64'(writesys), 64'd1);
      step(c_ins(5'h04, 6'h00), 1'b0, 32'd1, 32'd2, 32'd0, 1'b0);
      chk("mtc0_user_bad", 64'(badinstr), 64'd1);
      step(c_ins(5'h10, 6'h18), 1'b1, 32'd1, 32'd2, 32'd0, 1'b0);
      step(c_ins(5'h10, 6'h19), 1'b1, 32'd1, 32'd2, 32'd0, 1'b0);
      step({6'h3F, 26'h0}, 1'b1, 32'd9, 32'd9, 32'd0, 1'b0);
      chk("op3f_bad", 64'(badinstr), 64'd1);
      step(i_ins(6'h0F), 1'b0, 32'd0, 32'd0, 32'h0000_ABCD, 1'b0);
      chk("lui_result", 64'(alu_result), 64'hABCD_0000);
      step(r_ins(6'h03), 1'b0, 32'h8000_0000, 32'd4, 32'd0, 1'b0);
      chk("sra_result", 64'(alu_result), 64'hF800_0000);
      step(r_ins(6'h09), 1'b0, 32'h400, 32'd0, 32'd0, 1'b0);
      step(r_ins(6'h20), 1'b0, 32'd5, 32'd7, 32'd0, 1'b1);

      for (int n = 0; n < 400; n++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
         step(rnd_instr(), 1'($urandom_range(0, 1)), a, b, 32'($urandom),
              ($urandom_range(0, 19) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
